// File: rtl/cam_tag_array.sv
// Tag directory CAM: per-entry valid bits, registered lookup with priority-encoded hit,
// multi-hit flag, debug read port and a replacement-slot hint (lowest free, else round-robin).
module cam_tag_array #(
   parameter int TAG_W  = 6,
   parameter int DEPTH  = 16,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we_n,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [TAG_W-1:0]  din,
   input  logic              inv_n,
   input  logic              flush_n,
   input  logic              lk_req,
   input  logic [TAG_W-1:0]  argin,
   output logic              lk_ack,
   output logic [DEPTH-1:0]  mbits,
   output logic              hit,
   output logic [ADDR_W-1:0] hit_idx,
   output logic              multi_hit,
   input  logic              rd_n,
   input  logic [ADDR_W-1:0] raddr,
   output logic [TAG_W-1:0]  dout,
   output logic              dval,
   output logic              full,
   output logic [ADDR_W-1:0] free_idx
);

   logic [TAG_W-1:0]  tag_q [DEPTH];
   logic [TAG_W-1:0]  tag_d [DEPTH];
   logic [DEPTH-1:0]  valid_q, valid_d;
   logic [ADDR_W-1:0] rr_ptr_q, rr_ptr_d;
   logic              lk_ack_q, lk_ack_d;
   logic [DEPTH-1:0]  mbits_q, mbits_d;
   logic              hit_q, hit_d;
   logic [ADDR_W-1:0] hit_idx_q, hit_idx_d;
   logic              multi_hit_q, multi_hit_d;
   logic [TAG_W-1:0]  dout_q, dout_d;
   logic              dval_q, dval_d;

   logic [DEPTH-1:0]  match_c;
   logic [ADDR_W-1:0] hit_idx_c, free_idx_c;
   logic              full_c, waddr_ok, raddr_ok;

   assign waddr_ok = int'(waddr) < DEPTH;
   assign raddr_ok = int'(raddr) < DEPTH;
   assign full_c   = &valid_q;

   // Compare against pre-update state so same-edge writes cannot hit.
   always_comb begin
      match_c    = '0;
      hit_idx_c  = '0;
      free_idx_c = rr_ptr_q;
      for (int i = 0; i < DEPTH; i++)
         match_c[i] = valid_q[i] && (tag_q[i] == argin);
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (match_c[i])
            hit_idx_c = ADDR_W'(i);
         if (!full_c && !valid_q[i])
            free_idx_c = ADDR_W'(i);
      end
   end

   always_comb begin
      tag_d       = tag_q;
      valid_d     = valid_q;
      rr_ptr_d    = rr_ptr_q;
      lk_ack_d    = lk_req;
      mbits_d     = mbits_q;
      hit_d       = hit_q;
      hit_idx_d   = hit_idx_q;
      multi_hit_d = multi_hit_q;
      dout_d      = dout_q;
      dval_d      = dval_q;

      if (!we_n && waddr_ok)
         tag_d[waddr] = din;
      if (!flush_n) begin
         valid_d = '0;
      end else if (!we_n && waddr_ok) begin
         valid_d[waddr] = 1'b1;
         if (full_c)
            rr_ptr_d = (rr_ptr_q == ADDR_W'(DEPTH - 1)) ? '0 : rr_ptr_q + 1'b1;
      end else if (!inv_n && waddr_ok) begin
         valid_d[waddr] = 1'b0;
      end

      if (lk_req) begin
         mbits_d     = match_c;
         hit_d       = |match_c;
         hit_idx_d   = hit_idx_c;
         multi_hit_d = |(match_c & (match_c - DEPTH'(1)));
      end

      if (!rd_n) begin
         dout_d = raddr_ok ? tag_q[raddr] : '0;
         dval_d = raddr_ok ? valid_q[raddr] : 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++)
            tag_q[i] <= '1;
         valid_q     <= '0;
         rr_ptr_q    <= '0;
         lk_ack_q    <= 1'b0;
         mbits_q     <= '0;
         hit_q       <= 1'b0;
         hit_idx_q   <= '0;
         multi_hit_q <= 1'b0;
         dout_q      <= '0;
         dval_q      <= 1'b0;
      end else begin
         tag_q       <= tag_d;
         valid_q     <= valid_d;
         rr_ptr_q    <= rr_ptr_d;
         lk_ack_q    <= lk_ack_d;
         mbits_q     <= mbits_d;
         hit_q       <= hit_d;
         hit_idx_q   <= hit_idx_d;
         multi_hit_q <= multi_hit_d;
         dout_q      <= dout_d;
         dval_q      <= dval_d;
      end
   end

   assign lk_ack    = lk_ack_q;
   assign mbits     = mbits_q;
   assign hit       = hit_q;
   assign hit_idx   = hit_idx_q;
   assign multi_hit = multi_hit_q;
   assign dout      = dout_q;
   assign dval      = dval_q;
   assign full      = full_c;
   assign free_idx  = free_idx_c;

endmodule
